// File: rtl/dial_tracker_pkg.sv
// Shared constants, FSM state type and tag layout for the dial tracker.
package dial_tracker_pkg;

  localparam int unsigned DIAL_SIZE = 100;
  localparam logic        DIR_L     = 1'b0;
  localparam logic        DIR_R     = 1'b1;
  localparam int unsigned CNT_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic valid;
    logic dir;
    logic last;
  } tag_t;

endpackage

// File: rtl/dial_tracker_if.sv
// Command beat plus the aligned mod-100 stage result feeding the dial tracker.
interface dial_tracker_if;
  logic       cmd_valid;
  logic       cmd_dir;
  logic       cmd_last;
  logic [7:0] rot_by;
  logic [9:0] quotient;

  modport master (output cmd_valid, cmd_dir, cmd_last, rot_by, quotient);
  modport slave  (input  cmd_valid, cmd_dir, cmd_last, rot_by, quotient);
endinterface

// File: rtl/dial_tracker_tag_delay.sv
// Fixed-depth shift register with async reset and synchronous flush.
module tag_delay #(
  parameter int unsigned WIDTH = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
    end else begin
      sr[0] <= d;
      for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[DEPTH-1];

endmodule

// File: rtl/dial_tracker.sv
// Dial position tracker: aligns command tags with the mod-100 stage and
// counts landings on and passes through zero.
module dial_tracker
  import dial_tracker_pkg::*;
#(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned START_POS = 50,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  dial_tracker_if.slave    cmd,
  output logic [6:0]       dial_pos,
  output logic [CNT_W-1:0] zero_lands,
  output logic [CNT_W-1:0] zero_passes,
  output logic             busy,
  output logic             done,
  output logic             range_err
);

  localparam int unsigned SUM_W = ((CNT_W > 10) ? CNT_W : 10) + 1;
  localparam logic [7:0]  DIAL  = 8'(DIAL_SIZE);

  state_t           state;
  tag_t             in_tag, a_tag;
  logic [7:0]       p8, sum8, new8;
  logic             extra, range_bad;
  logic [SUM_W-1:0] psum;
  logic [CNT_W-1:0] passes_nx, lands_nx;

  assign in_tag = {cmd.cmd_valid, cmd.cmd_dir, cmd.cmd_last};

  // start flushes the line so beats issued before it never reach the datapath
  tag_delay #(.WIDTH($bits(tag_t)), .DEPTH(LATENCY)) u_tag_delay (
    .clk   (clk),
    .rst   (rst),
    .flush (start),
    .d     (in_tag),
    .q     (a_tag)
  );

  always_comb begin
    p8        = {1'b0, dial_pos};
    sum8      = p8 + cmd.rot_by;
    range_bad = (cmd.rot_by >= DIAL);
    if (a_tag.dir == DIR_R) begin
      extra = (sum8 >= DIAL);
      new8  = extra ? sum8 - DIAL : sum8;
    end else begin
      extra = (p8 != '0) && (cmd.rot_by >= p8);
      new8  = (cmd.rot_by > p8) ? p8 + DIAL - cmd.rot_by : p8 - cmd.rot_by;
    end
    // widened sum so any carry past CNT_W bits clamps to all-ones
    psum      = SUM_W'(zero_passes) + SUM_W'(cmd.quotient) + SUM_W'(extra);
    passes_nx = (|psum[SUM_W-1:CNT_W]) ? '1 : psum[CNT_W-1:0];
    lands_nx  = ((new8 == '0) && !(&zero_lands)) ? zero_lands + 1'b1 : zero_lands;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      dial_pos    <= 7'(START_POS);
      zero_lands  <= '0;
      zero_passes <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      range_err   <= 1'b0;
    end else if (start) begin
      state       <= ST_RUN;
      dial_pos    <= 7'(START_POS);
      zero_lands  <= '0;
      zero_passes <= '0;
      busy        <= 1'b1;
      done        <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (a_tag.valid) begin
            if (range_bad) begin
              range_err <= 1'b1;
            end else begin
              dial_pos    <= new8[6:0];
              zero_passes <= passes_nx;
              zero_lands  <= lands_nx;
            end
            if (a_tag.last) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dial_tracker.sv
// Scoreboard bench for dial_tracker with a behavioural mod-100 stage and dial model.
module tb_dial_tracker;
  import dial_tracker_pkg::*;

  localparam int unsigned LAT  = 4;
  localparam int unsigned CW   = 10;
  localparam int          MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [6:0]    dial_pos;
  logic [CW-1:0] zero_lands, zero_passes;
  logic          busy, done, range_err;

  dial_tracker_if bus ();

  dial_tracker #(.LATENCY(LAT), .START_POS(50), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cmd         (bus.slave),
    .dial_pos    (dial_pos),
    .zero_lands  (zero_lands),
    .zero_passes (zero_passes),
    .busy        (busy),
    .done        (done),
    .range_err   (range_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // upstream mod-100 stage: LAT-cycle pipeline of the raw magnitude; frc overrides rot_by with 120
  int  in_data = 0;
  bit  frc_in  = 0;
  int  pipe_n [LAT];
  bit  pipe_f [LAT];
  initial for (int i = 0; i < LAT; i++) begin pipe_n[i] = 0; pipe_f[i] = 0; end
  always @(posedge clk) begin
    pipe_n[0] <= in_data;
    pipe_f[0] <= frc_in;
    for (int i = 1; i < LAT; i++) begin
      pipe_n[i] <= pipe_n[i-1];
      pipe_f[i] <= pipe_f[i-1];
    end
  end
  always_comb begin
    bus.rot_by   = pipe_f[LAT-1] ? 8'd120 : 8'(pipe_n[LAT-1] % 100);
    bus.quotient = 10'(pipe_n[LAT-1] / 100);
  end

  // reference model: whole-number dial arithmetic, state 0=idle 1=run 2=done
  int m_pos, m_lands, m_passes, m_st;
  bit m_err;

  typedef struct {
    int    due;
    int    pos, lands, passes;
    bit    bsy, dn, err;
    string name;
  } exp_t;
  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  function automatic int sat(int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  function automatic void model_reset(int st);
    m_pos = 50; m_lands = 0; m_passes = 0; m_err = 0; m_st = st;
  endfunction

  function automatic void model_apply(bit dir, int n, bit last, bit frc);
    int hits, np;
    if (m_st != 1) return;
    if (frc) m_err = 1;
    else begin
      if (dir == DIR_R) begin
        hits = (m_pos + n) / 100;
        np   = (m_pos + n) % 100;
      end else begin
        if (m_pos == 0)     hits = n / 100;
        else if (n >= m_pos) hits = (n - m_pos) / 100 + 1;
        else                hits = 0;
        np = ((m_pos - n) % 100 + 100) % 100;
      end
      m_passes = sat(m_passes + hits);
      if (np == 0) m_lands = sat(m_lands + 1);
      m_pos = np;
    end
    if (last) m_st = 2;
  endfunction

  function automatic exp_t snap(string name, int due);
    exp_t e;
    e.due = due; e.name = name;
    e.pos = m_pos; e.lands = m_lands; e.passes = m_passes;
    e.bsy = (m_st == 1); e.dn = (m_st == 2); e.err = m_err;
    return e;
  endfunction

  // monitor: compare the head entry at exactly its due cycle
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      e = exp_q.pop_front();
      checks++; errors++;
      $display("FAIL %s: check missed (due %0d, now %0d)", e.name, e.due, cyc);
    end
    while (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      checks++;
      if (int'(dial_pos) != e.pos || int'(zero_lands) != e.lands || int'(zero_passes) != e.passes ||
          busy != e.bsy || done != e.dn || range_err != e.err) begin
        errors++;
        $display("FAIL %s @%0d: got pos=%0d lands=%0d passes=%0d busy=%0b done=%0b err=%0b, expected pos=%0d lands=%0d passes=%0d busy=%0b done=%0b err=%0b",
                 e.name, cyc, dial_pos, zero_lands, zero_passes, busy, done, range_err,
                 e.pos, e.lands, e.passes, e.bsy, e.dn, e.err);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    bus.cmd_valid = 0; bus.cmd_last = 0; frc_in = 0;
    repeat (n) tick();
  endtask

  task automatic send(string name, bit dir, int n, bit last, bit frc = 0, bit apply = 1, bit pre = 0);
    bus.cmd_valid = 1; bus.cmd_dir = dir; bus.cmd_last = last;
    in_data = n; frc_in = frc;
    if (pre) exp_q.push_back(snap({name, "_pre"}, cyc + 4));
    if (apply) begin
      model_apply(dir, n, last, frc);
      exp_q.push_back(snap(name, cyc + 5));
    end
    tick();
    bus.cmd_valid = 0; bus.cmd_last = 0; frc_in = 0;
  endtask

  task automatic do_start(string name);
    start = 1;
    model_reset(1);
    exp_q.push_back(snap(name, cyc + 1));
    tick();
    start = 0;
  endtask

  task automatic drain();
    int budget = 64;
    while (exp_q.size() > 0 && budget > 0) begin tick(); budget--; end
    if (exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d entries pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required completion", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  int aoc_n[10] = '{68, 30, 48, 5, 60, 55, 1, 99, 14, 82};
  bit aoc_d[10] = '{0, 0, 1, 0, 1, 0, 0, 0, 1, 0};

  initial begin
    rst = 1; start = 0;
    bus.cmd_valid = 0; bus.cmd_dir = 0; bus.cmd_last = 0;
    tick();
    model_reset(0);
    exp_q.push_back(snap("reset", cyc));
    tick();
    rst = 0;
    idle(2);

    // basic R and L rotations
    do_start("start1");
    send("r60", DIR_R, 60, 0, 0, 1, 1);
    idle(6);
    send("l10", DIR_L, 10, 0, 0, 1, 1);
    idle(6);
    send("l5_from0", DIR_L, 5, 0);
    drain();

    // multi-turn rotations
    do_start("start3");
    send("l250", DIR_L, 250, 0);
    send("r1000", DIR_R, 1000, 0);
    drain();

    // worked example sequence back-to-back, then a beat in DONE
    do_start("start_aoc");
    for (int i = 0; i < 10; i++) send($sformatf("aoc%0d", i), aoc_d[i], aoc_n[i], i == 9);
    send("in_done", DIR_R, 10, 0);
    drain();

    // start coinciding with an aligned beat drops it
    do_start("start5");
    send("dropped", DIR_R, 60, 0, 0, 0);
    idle(3);
    do_start("start_vs_beat");
    idle(8);
    exp_q.push_back(snap("after_drop", cyc));
    tick();

    // reset mid-run with beats in flight
    send("inflight", DIR_R, 30, 0, 0, 0);
    idle(1);
    rst = 1;
    model_reset(0);
    exp_q.push_back(snap("rst_mid", cyc));
    tick();
    rst = 0;
    idle(8);
    exp_q.push_back(snap("post_rst", cyc));
    drain();

    // out-of-range rot_by, then start clears range_err
    do_start("start6");
    send("r20", DIR_R, 20, 0);
    send("bad", DIR_R, 33, 0, 1);
    send("l5_after_bad", DIR_L, 5, 0);
    drain();
    do_start("start_clr");

    // counter saturation
    send("big1", DIR_R, 99999, 0);
    send("big2", DIR_R, 99999, 0);
    send("to0", DIR_R, 51, 0);
    for (int i = 0; i < 1030; i++) send($sformatf("sat%0d", i), DIR_R, 100, 0);
    drain();

    // randomized sequence
    do_start("start_rand");
    for (int i = 0; i < 60; i++) begin
      bit d, f;
      int n;
      d = 1'($urandom_range(0, 1));
      n = (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 1999));
      f = ($urandom_range(0, 15) == 0);
      send($sformatf("rnd%0d", i), d, n, i == 59, f);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    send("rnd_after_done", DIR_L, 37, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
